window_scheduler: RTL

WINDOW_SCHEDULER -- requirements
Module: window_scheduler

---
 rtl/window_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/window_scheduler.sv
// Loads an N x N image into external synchronous RAM, then walks every interior
// centre and presents the 3x3 neighbourhood to a downstream kernel via valid/ready.
module window_scheduler #(
    parameter int N          = 8,
    parameter int pixelWidth = 8,
    parameter int bitSize    = $clog2(N*N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [pixelWidth-1:0]   in_data,
    output logic                    ram_we,
    output logic [bitSize-1:0]      ram_addr,
    output logic [pixelWidth-1:0]   ram_wdata,
    input  logic [pixelWidth-1:0]   ram_rdata,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [9*pixelWidth-1:0] win_data,
    output logic [bitSize-1:0]      win_row,
    output logic [bitSize-1:0]      win_col,
    output logic                    busy,
    output logic                    done
);

    localparam int AW = bitSize + 2;
    localparam logic [bitSize-1:0] LAST_ADDR = bitSize'(N*N-1);
    localparam logic [bitSize-1:0] LAST_RC   = bitSize'(N-2);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, EMIT, DONE} state_t;

    state_t             state_reg, state_next;
    logic [bitSize-1:0] load_cnt_reg;
    logic [bitSize-1:0] row_reg, col_reg;
    logic [3:0]         fetch_cnt_reg;

    logic               accept;
    logic               last_win;
    logic [3:0]         tap_k;
    logic [1:0]         dr, dc;
    logic [AW-1:0]      tap_row, tap_col, tap_addr;

    assign accept   = in_valid && (state_reg == LOAD);
    assign last_win = (row_reg == LAST_RC) && (col_reg == LAST_RC);

    // Tap address for the current FETCH cycle; cycle 9 just holds tap 8.
    always_comb begin
        tap_k = (fetch_cnt_reg > 4'd8) ? 4'd8 : fetch_cnt_reg;
        dr = 2'd0;
        dc = 2'd0;
        case (tap_k)
            4'd0, 4'd1, 4'd2: dr = 2'd0;
            4'd3, 4'd4, 4'd5: dr = 2'd1;
            default:          dr = 2'd2;
        endcase
        case (tap_k)
            4'd0, 4'd3, 4'd6: dc = 2'd0;
            4'd1, 4'd4, 4'd7: dc = 2'd1;
            default:          dc = 2'd2;
        endcase
        tap_row  = AW'(row_reg) + AW'(dr) - AW'(1);
        tap_col  = AW'(col_reg) + AW'(dc) - AW'(1);
        tap_addr = tap_row * AW'(N) + tap_col;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  if (accept && load_cnt_reg == LAST_ADDR) state_next = FETCH;
            FETCH: if (fetch_cnt_reg == 4'd9) state_next = EMIT;
            EMIT:  if (win_ready) state_next = last_win ? DONE : FETCH;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            load_cnt_reg  <= '0;
            fetch_cnt_reg <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        load_cnt_reg  <= '0;
                        fetch_cnt_reg <= '0;
                        row_reg       <= bitSize'(1);
                        col_reg       <= bitSize'(1);
                    end
                end
                LOAD: begin
                    if (accept) load_cnt_reg <= load_cnt_reg + bitSize'(1);
                end
                FETCH: begin
                    fetch_cnt_reg <= (fetch_cnt_reg == 4'd9) ? 4'd0 : fetch_cnt_reg + 4'd1;
                end
                EMIT: begin
                    // Coordinates of the final window are kept for inspection.
                    if (win_ready && !last_win) begin
                        if (col_reg == LAST_RC) begin
                            col_reg <= bitSize'(1);
                            row_reg <= row_reg + bitSize'(1);
                        end else begin
                            col_reg <= col_reg + bitSize'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM data for a tap arrives one cycle after its address, so tap gi lands
    // on the edge where the fetch counter reads gi+1.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            logic [pixelWidth-1:0] tap_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    tap_reg <= '0;
                end else if (state_reg == FETCH && fetch_cnt_reg == 4'(gi + 1)) begin
                    tap_reg <= ram_rdata;
                end
            end
            assign win_data[gi*pixelWidth +: pixelWidth] = tap_reg;
        end
    endgenerate

    always_comb begin
        in_ready  = (state_reg == LOAD);
        ram_we    = accept;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_reg == LOAD) begin
            ram_addr  = load_cnt_reg;
            ram_wdata = in_data;
        end else if (state_reg == FETCH) begin
            ram_addr  = tap_addr[bitSize-1:0];
        end
    end

    assign win_valid = (state_reg == EMIT);
    assign win_row   = row_reg;
    assign win_col   = col_reg;
    assign busy      = (state_reg == LOAD) || (state_reg == FETCH) || (state_reg == EMIT);
    assign done      = (state_reg == DONE);

endmodule
